// File: rtl/tactile_pkg.sv
// Shared types, widths and the threshold-window helper for the taxel scanner.
package tactile_pkg;

    localparam int ADC_W = 12;
    // Widest row/col index a pixel record can carry; narrower scans zero-extend.
    localparam int IDX_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CONVERT,
        ST_WAIT_ADC,
        ST_EMIT
    } scan_state_t;

    typedef struct packed {
        logic [ADC_W-1:0] data;
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
        logic             hit;
        logic             err;
    } pixel_t;

    // An inverted window (lower > upper) can never satisfy both compares.
    function automatic logic in_window(input logic [ADC_W-1:0] data,
                                       input logic [ADC_W-1:0] lower,
                                       input logic [ADC_W-1:0] upper,
                                       input logic             thr_on);
        return !thr_on || ((data >= lower) && (data <= upper));
    endfunction

endpackage

// File: rtl/taxel_scan_controller_if.sv
// ADC conversion handshake and pixel output stream of the taxel scanner.
interface taxel_scan_controller_if #(
    parameter int RW = 2,
    parameter int CW = 2
);
    import tactile_pkg::*;

    logic             adc_start_out;
    logic             adc_done_in;
    logic [ADC_W-1:0] adc_data_in;
    logic             pix_valid_out;
    logic             pix_ready_in;
    logic [ADC_W-1:0] pix_data_out;
    logic [RW-1:0]    pix_row_out;
    logic [CW-1:0]    pix_col_out;
    logic             pix_hit_out;
    logic             pix_err_out;

    modport master (
        output adc_start_out, pix_valid_out, pix_data_out, pix_row_out,
               pix_col_out, pix_hit_out, pix_err_out,
        input  adc_done_in, adc_data_in, pix_ready_in
    );

    modport slave (
        input  adc_start_out, pix_valid_out, pix_data_out, pix_row_out,
               pix_col_out, pix_hit_out, pix_err_out,
        output adc_done_in, adc_data_in, pix_ready_in
    );

endinterface

// File: rtl/scan_index_counter.sv
// Row-major taxel index: column advances first, wraps into the next row.
module scan_index_counter #(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      clear_in,
    input  logic                      advance_in,
    output logic [$clog2(ROWS)-1:0]   row_out,
    output logic [$clog2(COLS)-1:0]   col_out,
    output logic                      last_out
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          w_row_end;
    logic          w_col_end;

    assign w_row_end = (r_row == RW'(ROWS - 1));
    assign w_col_end = (r_col == CW'(COLS - 1));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_row <= '0;
            r_col <= '0;
        end else if (clear_in) begin
            r_row <= '0;
            r_col <= '0;
        end else if (advance_in) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign row_out  = r_row;
    assign col_out  = r_col;
    assign last_out = w_row_end && w_col_end;

endmodule

// File: rtl/taxel_scan_controller.sv
// Taxel matrix scanner: settle mux, start ADC, window-threshold and stream pixels.
// Define SCAN_TIMEOUT_EN to bound the ADC wait and flag timed-out pixels via pix_err_out.
module taxel_scan_controller
    import tactile_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    enable_in,
    input  logic                    threshold_on_in,
    input  logic [ADC_W-1:0]        lower_bound_in,
    input  logic [ADC_W-1:0]        upper_bound_in,
    output logic [$clog2(ROWS)-1:0] row_sel_out,
    output logic [$clog2(COLS)-1:0] col_sel_out,
    output logic                    frame_done_out,
    output logic                    busy_out,
    taxel_scan_controller_if.master bus
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    scan_state_t      r_state, w_state_next;
    logic [SW-1:0]    r_settle_cnt;
    logic [ADC_W-1:0] r_lower, r_upper;
    logic             r_thr_on;
    pixel_t           r_pix;
    logic             r_frame_done;
    logic [RW-1:0]    w_row;
    logic [CW-1:0]    w_col;
    logic             w_last;
    logic             w_start_frame, w_capture, w_transfer;
    logic             w_unused;

    scan_index_counter #(.ROWS(ROWS), .COLS(COLS)) u_index (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .clear_in   (w_start_frame),
        .advance_in (w_transfer),
        .row_out    (w_row),
        .col_out    (w_col),
        .last_out   (w_last)
    );

`ifdef SCAN_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] r_wait_cnt;
    logic          w_timeout;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_wait_cnt <= '0;
        else         r_wait_cnt <= (r_state == ST_WAIT_ADC && w_state_next == ST_WAIT_ADC) ?
                                   r_wait_cnt + 1'b1 : '0;
    end
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_start_frame = 1'b0;
        w_capture     = 1'b0;
        w_transfer    = 1'b0;
`ifdef SCAN_TIMEOUT_EN
        w_timeout     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: if (enable_in) begin
                w_start_frame = 1'b1;
                w_state_next  = ST_SETTLE;
            end
            ST_SETTLE: if (r_settle_cnt == SW'(SETTLE_CYCLES - 1)) w_state_next = ST_CONVERT;
            ST_CONVERT: w_state_next = ST_WAIT_ADC;
            ST_WAIT_ADC: begin
                if (bus.adc_done_in) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_EMIT;
                end
`ifdef SCAN_TIMEOUT_EN
                else if (r_wait_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_EMIT;
                end
`endif
            end
            ST_EMIT: if (bus.pix_ready_in) begin
                w_transfer = 1'b1;
                // Enable only matters at frame boundaries; a frame never aborts.
                if (!w_last) begin
                    w_state_next = ST_SETTLE;
                end else if (enable_in) begin
                    w_start_frame = 1'b1;
                    w_state_next  = ST_SETTLE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_settle_cnt <= '0;
            r_lower      <= '0;
            r_upper      <= '0;
            r_thr_on     <= 1'b0;
            r_pix        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_settle_cnt <= (r_state == ST_SETTLE && w_state_next == ST_SETTLE) ?
                            r_settle_cnt + 1'b1 : '0;
            r_frame_done <= w_transfer && w_last;
            if (w_start_frame) begin
                r_lower  <= lower_bound_in;
                r_upper  <= upper_bound_in;
                r_thr_on <= threshold_on_in;
            end
            if (w_capture) begin
                r_pix.data <= bus.adc_data_in;
                r_pix.row  <= IDX_W'(w_row);
                r_pix.col  <= IDX_W'(w_col);
                r_pix.hit  <= in_window(bus.adc_data_in, r_lower, r_upper, r_thr_on);
                r_pix.err  <= 1'b0;
            end
`ifdef SCAN_TIMEOUT_EN
            if (w_timeout) begin
                r_pix.data <= '0;
                r_pix.row  <= IDX_W'(w_row);
                r_pix.col  <= IDX_W'(w_col);
                r_pix.hit  <= 1'b0;
                r_pix.err  <= 1'b1;
            end
`endif
        end
    end

    assign row_sel_out       = w_row;
    assign col_sel_out       = w_col;
    assign busy_out          = (r_state != ST_IDLE);
    assign frame_done_out    = r_frame_done;
    assign bus.adc_start_out = (r_state == ST_CONVERT);
    assign bus.pix_valid_out = (r_state == ST_EMIT);
    assign bus.pix_data_out  = r_pix.data;
    assign bus.pix_row_out   = r_pix.row[RW-1:0];
    assign bus.pix_col_out   = r_pix.col[CW-1:0];
    assign bus.pix_hit_out   = r_pix.hit;
`ifdef SCAN_TIMEOUT_EN
    assign bus.pix_err_out   = r_pix.err;
    assign w_unused          = ^{r_pix.row, r_pix.col};
`else
    assign bus.pix_err_out   = 1'b0;
    assign w_unused          = ^{r_pix.row, r_pix.col, r_pix.err, (TIMEOUT_CYCLES != 0)};
`endif

endmodule

// File: tb/tb_taxel_scan_controller.sv
// Self-checking bench: 2x2 scan, 3-clock ADC model, row-major/window reference model.
`timescale 1ns/1ps
module tb_taxel_scan_controller;
    import tactile_pkg::*;

    localparam int ROWS    = 2;
    localparam int COLS    = 2;
    localparam int SETTLE  = 2;
    localparam int TMO     = 16;
    localparam int ADC_LAT = 3;
    localparam int NPIX    = ROWS * COLS;
    localparam int RW      = $clog2(ROWS);
    localparam int CW      = $clog2(COLS);
    localparam int PERIOD  = SETTLE + 1 + ADC_LAT + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             thr_on = 1'b0;
    logic [ADC_W-1:0] lower = '0;
    logic [ADC_W-1:0] upper = '0;
    logic [RW-1:0]    row_sel;
    logic [CW-1:0]    col_sel;
    logic             frame_done;
    logic             busy;

    taxel_scan_controller_if #(.RW(RW), .CW(CW)) bus ();

    taxel_scan_controller #(
        .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .enable_in       (enable),
        .threshold_on_in (thr_on),
        .lower_bound_in  (lower),
        .upper_bound_in  (upper),
        .row_sel_out     (row_sel),
        .col_sel_out     (col_sel),
        .frame_done_out  (frame_done),
        .busy_out        (busy),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pcyc = 0;

    initial forever begin
        @(posedge clk);
        pcyc++;
    end

    // ADC model: done pulse ADC_LAT clocks after the start pulse.
    bit               adc_respond = 1'b1;
    logic [ADC_W-1:0] stim_q[$];
    int               start_cyc_q[$];

    initial begin
        int cnt;
        cnt = 0;
        bus.adc_done_in = 1'b0;
        bus.adc_data_in = '0;
        forever begin
            @(negedge clk);
            bus.adc_done_in = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && adc_respond) begin
                    if (stim_q.size() > 0) bus.adc_data_in = stim_q.pop_front();
                    else                   bus.adc_data_in = ADC_W'($urandom_range(0, 4095));
                    bus.adc_done_in = 1'b1;
                end
            end
            if (bus.adc_start_out) begin
                cnt = ADC_LAT;
                start_cyc_q.push_back(pcyc);
            end
        end
    end

    typedef struct {
        logic [ADC_W-1:0] data;
        int               row;
        int               col;
        logic             hit;
        logic             err;
        int               cyc;
    } pix_t;

    pix_t got_q[$];
    int   fd_cnt = 0;
    bit   rand_ready = 1'b0;
    bit   hold_low = 1'b0;

    // Pixel sink: drives ready, records each completed transfer.
    initial begin
        pix_t p;
        bus.pix_ready_in = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_low && bus.pix_valid_out && int'(bus.pix_row_out) == 0 && int'(bus.pix_col_out) == 1)
                bus.pix_ready_in = 1'b0;
            else if (rand_ready)
                bus.pix_ready_in = 1'($urandom_range(0, 1));
            else
                bus.pix_ready_in = 1'b1;
            if (bus.pix_valid_out && bus.pix_ready_in) begin
                p.data = bus.pix_data_out;
                p.row  = int'(bus.pix_row_out);
                p.col  = int'(bus.pix_col_out);
                p.hit  = bus.pix_hit_out;
                p.err  = bus.pix_err_out;
                p.cyc  = pcyc;
                got_q.push_back(p);
                $display("pixel (%0d,%0d) data=%0d hit=%b err=%b cyc=%0d", p.row, p.col, p.data, p.hit, p.err, p.cyc);
            end
            if (frame_done) fd_cnt++;
        end
    end

    function automatic logic [21:0] all_outs();
        return {busy, frame_done, row_sel, col_sel, bus.adc_start_out, bus.pix_valid_out,
                bus.pix_data_out, bus.pix_row_out, bus.pix_col_out, bus.pix_hit_out, bus.pix_err_out};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_pix(input int n, output bit ok);
        int k;
        k = 0;
        while (got_q.size() < n && k < 4000) begin
            tick(1);
            k++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic wait_idle(output bit ok);
        int k;
        k = 0;
        while (busy && k < 200) begin
            tick(1);
            k++;
        end
        ok = !busy;
        tick(2);
    endtask

    task automatic clear_logs();
        got_q.delete();
        stim_q.delete();
        start_cyc_q.delete();
    endtask

    // Pulse enable for one frame and wait for it to drain; no comparisons here.
    task automatic run_frame(output bit ok);
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        wait_pix(NPIX, ok);
        if (ok) wait_idle(ok);
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", all_outs());
        end
        rst_n = 1'b1;
        tick(3);
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b frame_done=%b want 0 0", busy, frame_done);
        end
    endtask

    task automatic test_frame();
        bit ok;
        int fd0;
        clear_logs();
        thr_on = 1'b0;
        fd0 = fd_cnt;
        for (int i = 0; i < NPIX; i++) stim_q.push_back(ADC_W'(100 * (i + 1)));
        run_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL frame_complete got pixels=%0d busy=%b want %0d 0", got_q.size(), busy, NPIX);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== ADC_W'(100 * (i + 1)) || got_q[i].row != i / COLS ||
                got_q[i].col != i % COLS || got_q[i].hit !== 1'b1 || got_q[i].err !== 1'b0) begin
                errors++;
                $display("FAIL frame_pix%0d got d=%0d (%0d,%0d) hit=%b err=%b want d=%0d (%0d,%0d) hit=1 err=0",
                         i, got_q[i].data, got_q[i].row, got_q[i].col, got_q[i].hit, got_q[i].err,
                         100 * (i + 1), i / COLS, i % COLS);
            end
            if (i < start_cyc_q.size()) begin
                checks++;
                if (got_q[i].cyc - start_cyc_q[i] != ADC_LAT + 1) begin
                    errors++;
                    $display("FAIL frame_latency%0d got %0d want %0d", i, got_q[i].cyc - start_cyc_q[i], ADC_LAT + 1);
                end
            end
            if (i > 0) begin
                checks++;
                if (got_q[i].cyc - got_q[i-1].cyc != PERIOD) begin
                    errors++;
                    $display("FAIL frame_period%0d got %0d want %0d", i, got_q[i].cyc - got_q[i-1].cyc, PERIOD);
                end
            end
        end
        checks++;
        if (fd_cnt - fd0 != 1) begin
            errors++;
            $display("FAIL frame_done_count got %0d want 1", fd_cnt - fd0);
        end
    endtask

    task automatic test_threshold();
        bit ok;
        logic [ADC_W-1:0] samp [4];
        logic             want [4];
        clear_logs();
        samp = '{12'd100, 12'd150, 12'd300, 12'd301};
        want = '{1'b0, 1'b1, 1'b1, 1'b0};
        thr_on = 1'b1;
        lower = 12'd150;
        upper = 12'd300;
        for (int i = 0; i < NPIX; i++) stim_q.push_back(samp[i]);
        run_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL thresh_complete got pixels=%0d want %0d", got_q.size(), NPIX);
        end
        for (int i = 0; i < got_q.size() && i < NPIX; i++) begin
            checks++;
            if (got_q[i].hit !== want[i] || got_q[i].data !== samp[i]) begin
                errors++;
                $display("FAIL thresh_pix%0d got d=%0d hit=%b want d=%0d hit=%b",
                         i, got_q[i].data, got_q[i].hit, samp[i], want[i]);
            end
        end
    endtask

    task automatic test_window();
        bit ok;
        logic [ADC_W-1:0] samp [4];
        samp = '{12'd100, 12'd300, 12'd500, 12'd4095};
        for (int pass = 0; pass < 2; pass++) begin
            clear_logs();
            thr_on = (pass == 0);
            lower = 12'd500;
            upper = 12'd100;
            for (int i = 0; i < NPIX; i++) stim_q.push_back(samp[i]);
            run_frame(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL window%0d_complete got pixels=%0d want %0d", pass, got_q.size(), NPIX);
            end
            for (int i = 0; i < got_q.size() && i < NPIX; i++) begin
                checks++;
                if (got_q[i].hit !== (pass == 1) || got_q[i].data !== samp[i]) begin
                    errors++;
                    $display("FAIL window%0d_pix%0d got d=%0d hit=%b want d=%0d hit=%b",
                             pass, i, got_q[i].data, got_q[i].hit, samp[i], pass == 1);
                end
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        int k;
        int starts0;
        logic [21:0] snap;
        clear_logs();
        thr_on = 1'b0;
        hold_low = 1'b1;
        for (int i = 0; i < NPIX; i++) stim_q.push_back(ADC_W'($urandom_range(0, 4095)));
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        k = 0;
        while (!(bus.pix_valid_out && int'(bus.pix_row_out) == 0 && int'(bus.pix_col_out) == 1) && k < 200) begin
            tick(1);
            k++;
        end
        checks++;
        if (k >= 200) begin
            errors++;
            $display("FAIL stall_reach got no pixel (0,1) want valid at (0,1)");
        end
        snap = all_outs();
        starts0 = start_cyc_q.size();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick(1);
            checks++;
            if (all_outs() !== snap || bus.pix_valid_out !== 1'b1 || bus.pix_ready_in !== 1'b0 ||
                int'(row_sel) != 0 || int'(col_sel) != 1 || start_cyc_q.size() != starts0) begin
                errors++;
                $display("FAIL stall_hold%0d got outs=%h starts=%0d want outs=%h starts=%0d",
                         i, all_outs(), start_cyc_q.size(), snap, starts0);
            end
        end
        hold_low = 1'b0;
        wait_pix(NPIX, ok);
        if (ok) wait_idle(ok);
        checks++;
        if (!ok || got_q[1].row != 0 || got_q[1].col != 1 || got_q[1].data !== snap[15:4]) begin
            errors++;
            $display("FAIL stall_release got pixels=%0d want %0d with pixel1=(0,1) d=%0d",
                     got_q.size(), NPIX, snap[15:4]);
        end
    endtask

    task automatic test_bounds_change();
        bit ok;
        int fd0;
        logic want [8];
        clear_logs();
        fd0 = fd_cnt;
        want = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        thr_on = 1'b1;
        lower = 12'd0;
        upper = 12'd1000;
        for (int i = 0; i < 2 * NPIX; i++) stim_q.push_back((i % 2 == 0) ? 12'd500 : 12'd650);
        enable = 1'b1;
        wait_pix(1, ok);
        lower = 12'd600;
        upper = 12'd700;
        wait_pix(NPIX + 1, ok);
        enable = 1'b0;
        wait_pix(2 * NPIX, ok);
        if (ok) wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bounds_complete got pixels=%0d want %0d", got_q.size(), 2 * NPIX);
        end
        for (int i = 0; i < got_q.size() && i < 2 * NPIX; i++) begin
            checks++;
            if (got_q[i].hit !== want[i]) begin
                errors++;
                $display("FAIL bounds_pix%0d got hit=%b want %b", i, got_q[i].hit, want[i]);
            end
        end
        checks++;
        if (fd_cnt - fd0 != 2) begin
            errors++;
            $display("FAIL bounds_frames got %0d want 2", fd_cnt - fd0);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        int fd0;
        clear_logs();
        fd0 = fd_cnt;
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        k = 0;
        while (start_cyc_q.size() == 0 && k < 100) begin
            tick(1);
            k++;
        end
        tick(1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got %h want 0", all_outs());
        end
        tick(2);
        rst_n = 1'b1;
        tick(20);
        checks++;
        if (got_q.size() != 0 || fd_cnt != fd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_discard got pixels=%0d frames=%0d busy=%b want 0 0 0",
                     got_q.size(), fd_cnt - fd0, busy);
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [ADC_W-1:0] exp_d [NPIX];
        logic             want;
        rand_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            clear_logs();
            thr_on = 1'($urandom_range(0, 3) != 0);
            lower  = ADC_W'($urandom_range(0, 4095));
            upper  = ADC_W'($urandom_range(0, 4095));
            for (int i = 0; i < NPIX; i++) begin
                exp_d[i] = ADC_W'($urandom_range(0, 4095));
                stim_q.push_back(exp_d[i]);
            end
            run_frame(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rand%0d_complete got pixels=%0d want %0d", f, got_q.size(), NPIX);
            end
            for (int i = 0; i < got_q.size() && i < NPIX; i++) begin
                want = !thr_on || (exp_d[i] >= lower && exp_d[i] <= upper);
                checks++;
                if (got_q[i].data !== exp_d[i] || got_q[i].hit !== want ||
                    got_q[i].row != i / COLS || got_q[i].col != i % COLS) begin
                    errors++;
                    $display("FAIL rand%0d_pix%0d got d=%0d (%0d,%0d) hit=%b want d=%0d (%0d,%0d) hit=%b",
                             f, i, got_q[i].data, got_q[i].row, got_q[i].col, got_q[i].hit,
                             exp_d[i], i / COLS, i % COLS, want);
                end
            end
        end
        rand_ready = 1'b0;
    endtask

`ifdef SCAN_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        clear_logs();
        thr_on = 1'b0;
        adc_respond = 1'b0;
        run_frame(ok);
        adc_respond = 1'b1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout_complete got pixels=%0d want %0d", got_q.size(), NPIX);
        end
        for (int i = 0; i < got_q.size() && i < start_cyc_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== '0 || got_q[i].hit !== 1'b0 || got_q[i].err !== 1'b1 ||
                got_q[i].cyc - start_cyc_q[i] != TMO + 1) begin
                errors++;
                $display("FAIL timeout_pix%0d got d=%0d hit=%b err=%b lat=%0d want d=0 hit=0 err=1 lat=%0d",
                         i, got_q[i].data, got_q[i].hit, got_q[i].err, got_q[i].cyc - start_cyc_q[i], TMO + 1);
            end
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame();
        test_threshold();
        test_window();
        test_stall();
        test_bounds_change();
        test_reset_mid();
        test_random();
`ifdef SCAN_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
